// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer for the Tomasulo core
//
// Allocates one entry per issued instruction, answers two operand-readiness
// queries per cycle, captures RS/LS CDB results and retires the head in
// program order. A mispredicted jump at commit flushes the whole buffer and
// redirects fetch.
//
// Optional feature macro: ROB_BP_UPDATE_EN (branch predictor training outputs).
//
// Ports:
//   clk, rst, rdy                      clock, sync active-high reset, global enable
//   *_from_dispatcher / *_to_dispatcher allocation request, allocated id, operand queries
//   *_from_rs_cdb, *_from_ls_cdb       result broadcasts from the RS and LS buses
//   full_to_if                         fetch/issue stall
//   commit_*_to_reg                    regfile write on commit (registered, 1-cycle pulse)
//   commit_*_to_lsb                    store release on commit (registered, 1-cycle pulse)
//   rollback_flag, target_pc_to_if     mispredict flush pulse and redirect pc
//   bp_update_*                        predictor training pulse (ROB_BP_UPDATE_EN only)

module reorder_buffer #(
    parameter int DEPTH    = 16,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_dispatcher,
    input  logic [4:0]          rd_from_dispatcher,
    input  logic                is_jump_from_dispatcher,
    input  logic                is_store_from_dispatcher,
    input  logic                predicted_jump_from_dispatcher,
    input  logic [31:0]         pc_from_dispatcher,
    output logic [ROB_ID_W-1:0] rob_id_to_dispatcher,
    input  logic [ROB_ID_W-1:0] Q1_from_dispatcher,
    input  logic [ROB_ID_W-1:0] Q2_from_dispatcher,
    output logic                Q1_ready_to_dispatcher,
    output logic                Q2_ready_to_dispatcher,
    output logic [31:0]         ready_data1_to_dispatcher,
    output logic [31:0]         ready_data2_to_dispatcher,
    input  logic                valid_from_rs_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [31:0]         result_from_rs_cdb,
    input  logic                jump_flag_from_rs_cdb,
    input  logic [31:0]         target_pc_from_rs_cdb,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]         result_from_ls_cdb,
    output logic                full_to_if,
    output logic                commit_ena_to_reg,
    output logic [4:0]          commit_rd_to_reg,
    output logic [ROB_ID_W-1:0] commit_rob_id_to_reg,
    output logic [31:0]         commit_data_to_reg,
    output logic                commit_store_to_lsb,
    output logic [ROB_ID_W-1:0] commit_rob_id_to_lsb,
    output logic                rollback_flag,
    output logic [31:0]         target_pc_to_if
`ifdef ROB_BP_UPDATE_EN
    ,
    output logic                bp_update_ena,
    output logic [31:0]         bp_update_pc,
    output logic                bp_update_taken
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Per-entry state
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_is_jump;
    logic [DEPTH-1:0] r_is_store;
    logic [DEPTH-1:0] r_pred;
    logic [DEPTH-1:0] r_actual_jump;
    logic [4:0]       r_rd        [DEPTH];
    logic [31:0]      r_pc        [DEPTH];
    logic [31:0]      r_result    [DEPTH];
    logic [31:0]      r_target_pc [DEPTH];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Id n lives in entry n-1; id 0 means "no dependency" and never matches.
    logic [IDX_W-1:0]    w_q1_idx, w_q2_idx, w_rs_idx, w_ls_idx;
    logic                w_rs_hit, w_ls_hit;
    logic                w_alloc, w_commit, w_mispredict;
    logic [ROB_ID_W-1:0] w_head_id;

    assign w_q1_idx = IDX_W'(Q1_from_dispatcher - ROB_ID_W'(1));
    assign w_q2_idx = IDX_W'(Q2_from_dispatcher - ROB_ID_W'(1));
    assign w_rs_idx = IDX_W'(rob_id_from_rs_cdb - ROB_ID_W'(1));
    assign w_ls_idx = IDX_W'(rob_id_from_ls_cdb - ROB_ID_W'(1));

    assign Q1_ready_to_dispatcher = (Q1_from_dispatcher != '0) && r_busy[w_q1_idx] && r_ready[w_q1_idx];
    assign Q2_ready_to_dispatcher = (Q2_from_dispatcher != '0) && r_busy[w_q2_idx] && r_ready[w_q2_idx];
    assign ready_data1_to_dispatcher = Q1_ready_to_dispatcher ? r_result[w_q1_idx] : 32'd0;
    assign ready_data2_to_dispatcher = Q2_ready_to_dispatcher ? r_result[w_q2_idx] : 32'd0;

    assign rob_id_to_dispatcher = ROB_ID_W'(r_tail) + ROB_ID_W'(1);
    // One slot of slack covers an instruction already past the stall point.
    assign full_to_if = (r_count >= CNT_W'(DEPTH - 1));

    // CDB writes only land on live entries; stale ids are dropped.
    assign w_rs_hit = valid_from_rs_cdb && (rob_id_from_rs_cdb != '0) && r_busy[w_rs_idx];
    assign w_ls_hit = valid_from_ls_cdb && (rob_id_from_ls_cdb != '0) && r_busy[w_ls_idx];

    assign w_alloc      = ena_from_dispatcher && (r_count < CNT_W'(DEPTH));
    assign w_commit     = (r_count != '0) && r_busy[r_head] && r_ready[r_head];
    assign w_mispredict = w_commit && r_is_jump[r_head] && (r_actual_jump[r_head] != r_pred[r_head]);
    assign w_head_id    = ROB_ID_W'(r_head) + ROB_ID_W'(1);

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy               <= '0;
            r_ready              <= '0;
            r_head               <= '0;
            r_tail               <= '0;
            r_count              <= '0;
            commit_ena_to_reg    <= 1'b0;
            commit_rd_to_reg     <= '0;
            commit_rob_id_to_reg <= '0;
            commit_data_to_reg   <= '0;
            commit_store_to_lsb  <= 1'b0;
            commit_rob_id_to_lsb <= '0;
            rollback_flag        <= 1'b0;
            target_pc_to_if      <= '0;
`ifdef ROB_BP_UPDATE_EN
            bp_update_ena        <= 1'b0;
            bp_update_pc         <= '0;
            bp_update_taken      <= 1'b0;
`endif
        end else if (!rdy) begin
            commit_ena_to_reg   <= 1'b0;
            commit_store_to_lsb <= 1'b0;
            rollback_flag       <= 1'b0;
`ifdef ROB_BP_UPDATE_EN
            bp_update_ena       <= 1'b0;
`endif
        end else begin
            commit_ena_to_reg   <= 1'b0;
            commit_store_to_lsb <= 1'b0;
            rollback_flag       <= 1'b0;
`ifdef ROB_BP_UPDATE_EN
            bp_update_ena       <= 1'b0;
`endif

            if (w_rs_hit) r_ready[w_rs_idx] <= 1'b1;
            if (w_ls_hit) r_ready[w_ls_idx] <= 1'b1;

            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
                if (r_is_store[r_head]) begin
                    commit_store_to_lsb  <= 1'b1;
                    commit_rob_id_to_lsb <= w_head_id;
                end else if (r_rd[r_head] != '0) begin
                    commit_ena_to_reg    <= 1'b1;
                    commit_rd_to_reg     <= r_rd[r_head];
                    commit_rob_id_to_reg <= w_head_id;
                    commit_data_to_reg   <= r_result[r_head];
                end
`ifdef ROB_BP_UPDATE_EN
                if (r_is_jump[r_head]) begin
                    bp_update_ena   <= 1'b1;
                    bp_update_pc    <= r_pc[r_head];
                    bp_update_taken <= r_actual_jump[r_head];
                end
`endif
            end

            // Allocation overrides any same-cycle CDB on the new entry.
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + IDX_W'(1);
            end

            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Flush wins over everything above, including this cycle's allocation.
            if (w_mispredict) begin
                r_busy          <= '0;
                r_ready         <= '0;
                r_head          <= '0;
                r_tail          <= '0;
                r_count         <= '0;
                rollback_flag   <= 1'b1;
                target_pc_to_if <= r_actual_jump[r_head] ? r_target_pc[r_head]
                                                         : r_pc[r_head] + 32'd4;
            end
        end
    end

    // Entry payload; only meaningful while the matching busy bit is set.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_rs_hit) begin
                r_result[w_rs_idx]      <= result_from_rs_cdb;
                r_actual_jump[w_rs_idx] <= jump_flag_from_rs_cdb;
                r_target_pc[w_rs_idx]   <= target_pc_from_rs_cdb;
            end
            if (w_ls_hit) begin
                r_result[w_ls_idx] <= result_from_ls_cdb;
            end
            if (w_alloc) begin
                r_rd[r_tail]       <= rd_from_dispatcher;
                r_is_jump[r_tail]  <= is_jump_from_dispatcher;
                r_is_store[r_tail] <= is_store_from_dispatcher;
                r_pred[r_tail]     <= predicted_jump_from_dispatcher;
                r_pc[r_tail]       <= pc_from_dispatcher;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard testbench for reorder_buffer

module tb_reorder_buffer;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          ena_from_dispatcher;
    logic [4:0]    rd_from_dispatcher;
    logic          is_jump_from_dispatcher, is_store_from_dispatcher, predicted_jump_from_dispatcher;
    logic [31:0]   pc_from_dispatcher;
    logic [RW-1:0] rob_id_to_dispatcher;
    logic [RW-1:0] Q1_from_dispatcher, Q2_from_dispatcher;
    logic          Q1_ready_to_dispatcher, Q2_ready_to_dispatcher;
    logic [31:0]   ready_data1_to_dispatcher, ready_data2_to_dispatcher;
    logic          valid_from_rs_cdb;
    logic [RW-1:0] rob_id_from_rs_cdb;
    logic [31:0]   result_from_rs_cdb;
    logic          jump_flag_from_rs_cdb;
    logic [31:0]   target_pc_from_rs_cdb;
    logic          valid_from_ls_cdb;
    logic [RW-1:0] rob_id_from_ls_cdb;
    logic [31:0]   result_from_ls_cdb;
    logic          full_to_if;
    logic          commit_ena_to_reg;
    logic [4:0]    commit_rd_to_reg;
    logic [RW-1:0] commit_rob_id_to_reg;
    logic [31:0]   commit_data_to_reg;
    logic          commit_store_to_lsb;
    logic [RW-1:0] commit_rob_id_to_lsb;
    logic          rollback_flag;
    logic [31:0]   target_pc_to_if;
`ifdef ROB_BP_UPDATE_EN
    logic          bp_update_ena;
    logic [31:0]   bp_update_pc;
    logic          bp_update_taken;
`endif

    reorder_buffer #(.DEPTH(16), .ROB_ID_W(RW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ena_from_dispatcher(ena_from_dispatcher),
        .rd_from_dispatcher(rd_from_dispatcher),
        .is_jump_from_dispatcher(is_jump_from_dispatcher),
        .is_store_from_dispatcher(is_store_from_dispatcher),
        .predicted_jump_from_dispatcher(predicted_jump_from_dispatcher),
        .pc_from_dispatcher(pc_from_dispatcher),
        .rob_id_to_dispatcher(rob_id_to_dispatcher),
        .Q1_from_dispatcher(Q1_from_dispatcher),
        .Q2_from_dispatcher(Q2_from_dispatcher),
        .Q1_ready_to_dispatcher(Q1_ready_to_dispatcher),
        .Q2_ready_to_dispatcher(Q2_ready_to_dispatcher),
        .ready_data1_to_dispatcher(ready_data1_to_dispatcher),
        .ready_data2_to_dispatcher(ready_data2_to_dispatcher),
        .valid_from_rs_cdb(valid_from_rs_cdb),
        .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
        .result_from_rs_cdb(result_from_rs_cdb),
        .jump_flag_from_rs_cdb(jump_flag_from_rs_cdb),
        .target_pc_from_rs_cdb(target_pc_from_rs_cdb),
        .valid_from_ls_cdb(valid_from_ls_cdb),
        .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
        .result_from_ls_cdb(result_from_ls_cdb),
        .full_to_if(full_to_if),
        .commit_ena_to_reg(commit_ena_to_reg),
        .commit_rd_to_reg(commit_rd_to_reg),
        .commit_rob_id_to_reg(commit_rob_id_to_reg),
        .commit_data_to_reg(commit_data_to_reg),
        .commit_store_to_lsb(commit_store_to_lsb),
        .commit_rob_id_to_lsb(commit_rob_id_to_lsb),
        .rollback_flag(rollback_flag),
        .target_pc_to_if(target_pc_to_if)
`ifdef ROB_BP_UPDATE_EN
        ,
        .bp_update_ena(bp_update_ena),
        .bp_update_pc(bp_update_pc),
        .bp_update_taken(bp_update_taken)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          reg_ena;
        logic [4:0]    rd;
        logic [RW-1:0] id;
        logic [31:0]   data;
        logic          store;
        logic          rb;
        logic [31:0]   tgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic reg_ena, input logic [4:0] rd, input logic [RW-1:0] id,
                            input logic [31:0] data, input logic store, input logic rb,
                            input logic [31:0] tgt);
        exp_t e;
        e.reg_ena = reg_ena; e.rd = rd; e.id = id; e.data = data;
        e.store = store; e.rb = rb; e.tgt = tgt;
        sb.push_back(e);
    endtask

    // Monitor: any commit-side pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (commit_ena_to_reg || commit_store_to_lsb || rollback_flag)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: got reg=%0b store=%0b rollback=%0b, expected none",
                         commit_ena_to_reg, commit_store_to_lsb, rollback_flag);
            end else begin
                mon_e = sb.pop_front();
                check("commit_reg_ena", 32'(commit_ena_to_reg), 32'(mon_e.reg_ena));
                if (mon_e.reg_ena) begin
                    check("commit_rd", 32'(commit_rd_to_reg), 32'(mon_e.rd));
                    check("commit_reg_id", 32'(commit_rob_id_to_reg), 32'(mon_e.id));
                    check("commit_data", commit_data_to_reg, mon_e.data);
                end
                check("commit_store", 32'(commit_store_to_lsb), 32'(mon_e.store));
                if (mon_e.store) check("commit_lsb_id", 32'(commit_rob_id_to_lsb), 32'(mon_e.id));
                check("rollback_flag", 32'(rollback_flag), 32'(mon_e.rb));
                if (mon_e.rb) check("rollback_target", target_pc_to_if, mon_e.tgt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic jmp, input logic st, input logic pred,
                         input logic [31:0] pc);
        ena_from_dispatcher = 1'b1;
        rd_from_dispatcher = rd;
        is_jump_from_dispatcher = jmp;
        is_store_from_dispatcher = st;
        predicted_jump_from_dispatcher = pred;
        pc_from_dispatcher = pc;
        tick();
        ena_from_dispatcher = 1'b0;
    endtask

    task automatic rs_cdb(input logic [RW-1:0] id, input logic [31:0] res, input logic jf,
                          input logic [31:0] tpc);
        valid_from_rs_cdb = 1'b1;
        rob_id_from_rs_cdb = id;
        result_from_rs_cdb = res;
        jump_flag_from_rs_cdb = jf;
        target_pc_from_rs_cdb = tpc;
        tick();
        valid_from_rs_cdb = 1'b0;
    endtask

    task automatic ls_cdb(input logic [RW-1:0] id, input logic [31:0] res);
        valid_from_ls_cdb = 1'b1;
        rob_id_from_ls_cdb = id;
        result_from_ls_cdb = res;
        tick();
        valid_from_ls_cdb = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        repeat (2) tick();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        ena_from_dispatcher = 1'b0; rd_from_dispatcher = '0;
        is_jump_from_dispatcher = 1'b0; is_store_from_dispatcher = 1'b0;
        predicted_jump_from_dispatcher = 1'b0; pc_from_dispatcher = '0;
        Q1_from_dispatcher = '0; Q2_from_dispatcher = '0;
        valid_from_rs_cdb = 1'b0; rob_id_from_rs_cdb = '0; result_from_rs_cdb = '0;
        jump_flag_from_rs_cdb = 1'b0; target_pc_from_rs_cdb = '0;
        valid_from_ls_cdb = 1'b0; rob_id_from_ls_cdb = '0; result_from_ls_cdb = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        Q1_from_dispatcher = 5'd1;
        #1;
        check("reset_rob_id", 32'(rob_id_to_dispatcher), 32'd1);
        check("reset_full", 32'(full_to_if), 32'd0);
        check("reset_commit_reg", 32'(commit_ena_to_reg), 32'd0);
        check("reset_commit_store", 32'(commit_store_to_lsb), 32'd0);
        check("reset_rollback", 32'(rollback_flag), 32'd0);
        check("reset_target_pc", target_pc_to_if, 32'd0);
        check("reset_q1_ready", 32'(Q1_ready_to_dispatcher), 32'd0);

        // Three allocations, ids 1..3
        for (int i = 0; i < 3; i++) begin
            check("alloc_id", 32'(rob_id_to_dispatcher), 32'(i + 1));
            alloc(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'(4 * i));
        end
        check("alloc_id_after3", 32'(rob_id_to_dispatcher), 32'd4);
        check("full_after3", 32'(full_to_if), 32'd0);

        // Out-of-order completion: id2 ready first, no commit yet
        rs_cdb(5'd2, 32'h55, 1'b0, 32'd0);
        Q1_from_dispatcher = 5'd2; Q2_from_dispatcher = 5'd1;
        #1;
        check("q1_ready_id2", 32'(Q1_ready_to_dispatcher), 32'd1);
        check("q1_data_id2", ready_data1_to_dispatcher, 32'h55);
        check("q2_ready_id1", 32'(Q2_ready_to_dispatcher), 32'd0);
        check("q2_data_id1", ready_data2_to_dispatcher, 32'd0);
        push_exp(1'b1, 5'd1, 5'd1, 32'h11, 1'b0, 1'b0, 32'd0);
        push_exp(1'b1, 5'd2, 5'd2, 32'h55, 1'b0, 1'b0, 32'd0);
        ls_cdb(5'd1, 32'h11);
        push_exp(1'b1, 5'd3, 5'd3, 32'h33, 1'b0, 1'b0, 32'd0);
        rs_cdb(5'd3, 32'h33, 1'b0, 32'd0);
        wait_drain("drain_first3");
        check("rob_id_after_first3", 32'(rob_id_to_dispatcher), 32'd4);

        // Fill: head=tail=3, ids 4..16 then 1,2,3
        for (int i = 0; i < 15; i++) begin
            if (i == 14) check("full_at14", 32'(full_to_if), 32'd0);
            alloc(5'd5, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(4 * i));
        end
        check("full_at15", 32'(full_to_if), 32'd1);
        check("rob_id_at15", 32'(rob_id_to_dispatcher), 32'd3);
        alloc(5'd5, 1'b0, 1'b0, 1'b0, 32'h200);
        check("rob_id_at16", 32'(rob_id_to_dispatcher), 32'd4);
        alloc(5'd5, 1'b0, 1'b0, 1'b0, 32'h204);
        check("rob_id_17th_ignored", 32'(rob_id_to_dispatcher), 32'd4);
        check("full_at16", 32'(full_to_if), 32'd1);

        // Drain with both CDBs writing different entries each cycle
        for (int k = 0; k < 16; k += 2) begin
            int ida, idb;
            ida = ((3 + k) % 16) + 1;
            idb = ((4 + k) % 16) + 1;
            push_exp(1'b1, 5'd5, 5'(ida), 32'h1000 + 32'(ida), 1'b0, 1'b0, 32'd0);
            push_exp(1'b1, 5'd5, 5'(idb), 32'h1000 + 32'(idb), 1'b0, 1'b0, 32'd0);
            valid_from_rs_cdb = 1'b1; rob_id_from_rs_cdb = 5'(ida);
            result_from_rs_cdb = 32'h1000 + 32'(ida); jump_flag_from_rs_cdb = 1'b0;
            valid_from_ls_cdb = 1'b1; rob_id_from_ls_cdb = 5'(idb);
            result_from_ls_cdb = 32'h1000 + 32'(idb);
            tick();
        end
        valid_from_rs_cdb = 1'b0; valid_from_ls_cdb = 1'b0;
        wait_drain("drain_full");
        check("rob_id_after_full", 32'(rob_id_to_dispatcher), 32'd4);
        check("full_after_drain", 32'(full_to_if), 32'd0);

        // Move head/tail to 15, then allocate+commit across the 15->0 wrap
        for (int i = 0; i < 12; i++) alloc(5'd6, 1'b0, 1'b0, 1'b0, 32'h300 + 32'(4 * i));
        for (int i = 0; i < 12; i++) begin
            push_exp(1'b1, 5'd6, 5'(4 + i), 32'h2000 + 32'(4 + i), 1'b0, 1'b0, 32'd0);
            ls_cdb(5'(4 + i), 32'h2000 + 32'(4 + i));
        end
        wait_drain("drain_to15");
        check("rob_id_16", 32'(rob_id_to_dispatcher), 32'd16);
        alloc(5'd8, 1'b0, 1'b0, 1'b0, 32'h60);
        push_exp(1'b1, 5'd8, 5'd16, 32'h16, 1'b0, 1'b0, 32'd0);
        ls_cdb(5'd16, 32'h16);
        check("rob_id_wrap_1", 32'(rob_id_to_dispatcher), 32'd1);
        alloc(5'd7, 1'b1, 1'b0, 1'b0, 32'h80);
        check("rob_id_after_wrap", 32'(rob_id_to_dispatcher), 32'd2);
        for (int i = 0; i < 13; i++) alloc(5'd9, 1'b0, 1'b0, 1'b0, 32'h400 + 32'(4 * i));
        check("full_count14", 32'(full_to_if), 32'd0);
        alloc(5'd9, 1'b0, 1'b0, 1'b0, 32'h500);
        check("full_count15", 32'(full_to_if), 32'd1);
        check("rob_id_count15", 32'(rob_id_to_dispatcher), 32'd16);

        // Mispredict at head id1 (pred not-taken, actual taken); allocation in flush cycle dropped
        push_exp(1'b1, 5'd7, 5'd1, 32'h84, 1'b0, 1'b1, 32'h100);
        rs_cdb(5'd1, 32'h84, 1'b1, 32'h100);
        alloc(5'd9, 1'b0, 1'b0, 1'b0, 32'h999);
        check("rob_id_after_rollback", 32'(rob_id_to_dispatcher), 32'd1);
        check("full_after_rollback", 32'(full_to_if), 32'd0);
        wait_drain("drain_rollback");
        Q1_from_dispatcher = 5'd2;
        #1;
        check("q1_flushed", 32'(Q1_ready_to_dispatcher), 32'd0);

        // CDB to a non-busy entry is ignored
        rs_cdb(5'd5, 32'h77, 1'b0, 32'd0);
        Q1_from_dispatcher = 5'd5;
        #1;
        check("q1_nonbusy", 32'(Q1_ready_to_dispatcher), 32'd0);

        // Store commit, correctly predicted jump, then mispredict predicted-taken
        alloc(5'd0, 1'b0, 1'b1, 1'b0, 32'h10);
        push_exp(1'b0, 5'd0, 5'd1, 32'd0, 1'b1, 1'b0, 32'd0);
        ls_cdb(5'd1, 32'hdead);
        alloc(5'd1, 1'b1, 1'b0, 1'b1, 32'h20);
        push_exp(1'b1, 5'd1, 5'd2, 32'h24, 1'b0, 1'b0, 32'd0);
        rs_cdb(5'd2, 32'h24, 1'b1, 32'h200);
        alloc(5'd0, 1'b1, 1'b0, 1'b1, 32'h40);
        push_exp(1'b0, 5'd0, 5'd3, 32'd0, 1'b0, 1'b1, 32'h44);
        rs_cdb(5'd3, 32'd0, 1'b0, 32'd0);
        wait_drain("drain_store_jump");
        check("rob_id_after_nt_rollback", 32'(rob_id_to_dispatcher), 32'd1);

        // rdy low freezes state
        rdy = 1'b0;
        alloc(5'd3, 1'b0, 1'b0, 1'b0, 32'h50);
        check("rob_id_rdy_low", 32'(rob_id_to_dispatcher), 32'd1);
        rdy = 1'b1;
        tick();
        check("rob_id_rdy_high", 32'(rob_id_to_dispatcher), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
